// File: rtl/debounce_pulse.sv
// Multi-channel switch debouncer: per-channel synchronizer, stability counter,
// registered debounced level with one-cycle rise/fall pulses and a toggle state.
module debounce_pulse #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] toggle
);

  localparam int             CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] toggle_q, toggle_d;

  // Synchronizer shifts every cycle, independent of en.
  always_comb begin
    sync_d[0] = din;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A level is accepted on the cycle the counter has already seen
  // DB_CYCLES-1 differing samples; any agreeing sample or en=0 restarts it.
  always_comb begin
    level_d  = level_q;
    rise_d   = '0;
    fall_d   = '0;
    toggle_d = toggle_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (en && (s[i] != level_q[i])) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]  = s[i];
          rise_d[i]   = s[i];
          fall_d[i]   = ~s[i];
          toggle_d[i] = toggle_q[i] ^ s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule
